// File: rtl/vec_alu_pkg.sv
// Shared types for the multi-cycle vector ALU: op codes and control states.
package vec_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_DUP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational single-lane ALU. The DUP source lane is chosen by the parent
// and arrives on dup_a, so this block never needs to see the whole vector.
module vec_alu_lane
    import vec_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  op_e          op,
    input  logic         sat,
    input  logic [N-1:0] dup_a,
    output logic [N-1:0] y
);

    localparam int SW = $clog2(N);

    logic [N:0]    w_sum;
    logic [N:0]    w_diff;
    logic [SW-1:0] w_sh;

    // One extra bit on add/sub exposes the carry (overflow) and borrow (underflow).
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_sh   = b[SW-1:0];

    // Per-lane operation select; saturation only affects ADD and SUB.
    always_comb begin
        // NOTE: y gets a default before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        y = '0;
        case (op)
            OP_ADD: y = (sat && w_sum[N])  ? {N{1'b1}} : w_sum[N-1:0];
            OP_SUB: y = (sat && w_diff[N]) ? '0        : w_diff[N-1:0];
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: y = a << w_sh;
            OP_SHR: y = a >> w_sh;
            OP_DUP: y = dup_a;
        endcase
    end

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle vector ALU: captures a V-lane operand bundle, computes P lanes
// per cycle over V/P passes, then holds the result until the consumer takes it.
module vec_alu_seq
    import vec_alu_pkg::*;
#(
    parameter int N = 8,
    parameter int V = 16,
    parameter int P = 16      // must divide V
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [V*N-1:0] a,
    input  logic [V*N-1:0] b,
    input  logic [2:0]     op,
    input  logic           sat,
    input  logic [V-1:0]   mask,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [V*N-1:0] result,
    output logic           zero
);

    localparam int PASSES = V / P;
    localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

    state_e         r_state;
    logic [CW-1:0]  r_cnt;
    logic [V*N-1:0] r_a;
    logic [V*N-1:0] r_b;
    op_e            r_op;
    logic           r_sat;
    logic [V-1:0]   r_mask;
    logic [V*N-1:0] r_result;
    logic           r_zero;
    logic           r_out_valid;
    logic           r_in_ready;

    logic [N-1:0]   w_lane_a   [P];
    logic [N-1:0]   w_lane_b   [P];
    logic [N-1:0]   w_lane_dup [P];
    logic [N-1:0]   w_lane_y   [P];
    logic [P-1:0]   w_lane_m;
    logic [V*N-1:0] w_next_result;
    logic           w_last;

    assign w_last = (r_cnt == CW'(PASSES - 1));

    // Route the lanes of the current pass onto the P lane ALUs; DUP may read
    // any lane of the captured A, not just those of this pass.
    always_comb begin
        for (int j = 0; j < P; j++) begin
            w_lane_a[j]   = '0;
            w_lane_b[j]   = '0;
            w_lane_dup[j] = '0;
        end
        w_lane_m = '0;
        for (int k = 0; k < PASSES; k++) begin
            if (r_cnt == CW'(k)) begin
                for (int j = 0; j < P; j++) begin
                    w_lane_a[j]   = r_a[(k*P + j)*N +: N];
                    w_lane_b[j]   = r_b[(k*P + j)*N +: N];
                    w_lane_dup[j] = r_a[((k*P + j)/2)*N +: N];
                    w_lane_m[j]   = r_mask[k*P + j];
                end
            end
        end
    end

    genvar gj;
    generate
        for (gj = 0; gj < P; gj++) begin : g_lane
            vec_alu_lane #(.N(N)) u_lane (
                .a     (w_lane_a[gj]),
                .b     (w_lane_b[gj]),
                .op    (r_op),
                .sat   (r_sat),
                .dup_a (w_lane_dup[gj]),
                .y     (w_lane_y[gj])
            );
        end
    endgenerate

    // Merge this pass's lanes into the held result; masked lanes pass A through.
    always_comb begin
        w_next_result = r_result;
        for (int i = 0; i < V; i++) begin
            if (r_cnt == CW'(i / P)) begin
                w_next_result[i*N +: N] = w_lane_m[i % P] ? w_lane_y[i % P]
                                                          : w_lane_a[i % P];
            end
        end
    end

    // Control FSM with registered handshake outputs, result and zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            // NOTE: operand capture registers are left out of reset; they are
            // always loaded at accept before anything reads them.
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // NOTE: all state uses non-blocking assignment so every
                        // register sees pre-edge values, independent of statement order.
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= op_e'(op);
                        r_sat      <= sat;
                        r_mask     <= mask;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_result <= w_next_result;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_zero      <= (w_next_result == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_zero      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Multi-cycle, parametrised vector ALU for the Execute stage of the vector datapath.
- Captures two V-lane x N-bit operand vectors with a valid/ready handshake.
- Processes P lanes per cycle over V/P passes, then holds the result until the consumer accepts it.
- Beyond plain per-lane ops, adds a per-lane write mask, an unsigned saturating add/sub mode, a lane-duplicate op and an all-zero flag.

Parameters:
- N, 8, lane width in bits (>=2).
- V, 16, number of lanes.
- P, 16, lanes processed per cycle. P must divide V. PASSES = V/P.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- a  in  V x N  operand vector A; lane i is bits [i*N +: N].
- b  in  V x N  operand vector B.
- op  in  3  operation code (see Behaviour).
- sat  in  1  saturate mode for ADD/SUB.
- mask  in  V  lane enable; 0 = lane result is A[i] unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  V x N  result vector.
- zero  out  1  all V lanes of result are 0.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, result=0, zero=0 after the edge.
  - Applies from any state, including mid-pass; the in-flight operation is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: a, b, op, sat and mask are captured; pass counter = 0; state goes to BUSY.
  - Inputs are sampled only at this accept edge.
- BUSY:
  - in_ready=0.
  - Each edge computes lanes [k*P +: P] from the captured operands and writes them into the result register; k increments.
  - After pass PASSES-1: state goes to DONE, out_valid=1 and zero is updated.
  - Latency: accept at edge T, out_valid high after edge T+PASSES.
- DONE:
  - out_valid=1; result and zero held stable.
  - On out_ready=1 at an edge: out_valid goes to 0 and state goes to IDLE.
  - in_ready stays 0 until back in IDLE, so there is no same-cycle accept.
- in_valid while not IDLE: ignored, no capture. The producer must hold in_valid until in_ready.
- Ops, per lane i, mod 2^N unless noted:
  - 000 ADD: A+B. With sat=1, unsigned clamp to 2^N-1.
  - 001 SUB: A-B. With sat=1, unsigned clamp to 0.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A << B[log2(N)-1:0].
  - 110 SHR: logical, A >> B[log2(N)-1:0].
  - 111 DUP: result[i] = A[i/2] (integer division). B is ignored.
- sat is ignored for ops other than ADD/SUB.
- DUP reads any lane of the captured A, regardless of the pass the result lane falls in.
- Mask: mask[i]=0 makes result[i] = A[i] for every op, including DUP.
- zero: 1 iff every result lane equals 0 (masked lanes included). Valid only while out_valid=1; 0 otherwise.
- Pass counter width is clog2(PASSES), minimum 1 bit. It wraps to 0 on entering DONE.

Decomposition:
- Package vec_alu_pkg holds:
  - typedef enum of the 3-bit op codes: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_DUP.
  - state enum: IDLE, BUSY, DONE.
- Sub-module vec_alu_lane: combinational single-lane ALU.
  - Inputs: a, b, op, sat; output: y; parameter N.
  - Instantiated P times via generate.
  - Its DUP input is pre-selected by the parent as A[i/2].

Test Plan (N=8, V=16; P=16 and P=4 both run):
- ADD, sat=0, all lanes A=0xF0, B=0x20, mask all 1 -> every lane 0x10, zero=0. out_valid rises 1 edge after accept (P=16) or 4 edges after (P=4).
- ADD, sat=1, A=0xF0, B=0x20 -> all lanes 0xFF. Then SUB, sat=1, A=0x10, B=0x20 -> all lanes 0x00, zero=1.
- DUP with A[i]=i, P=4 -> result = {0,0,1,1,...,7,7} (lane 0 first). mask=0x00FF -> lanes 8..15 keep A values 8..15.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Result stays stable and in_ready stays 0; a second bundle presented meanwhile is not captured. Assert out_ready -> accepted, in_ready=1 next cycle, and the second bundle is captured then.
- SHL/SHR: A=0x81, B=0x09 (shift 1) -> SHL 0x02, SHR 0x40. XOR of A with itself -> all 0, zero=1.
- Reset mid-op: P=4, assert rst after pass 2 -> next cycle in_ready=1, out_valid=0, result=0. A new op then completes with correct values.
